// File: rtl/bridge_dataslot_size_override_if.sv
// Bridge bus between host, this block and the dataslot table RAM.
//   addr/wr/wr_data/rd : request, driven by the master side
//   rd_data/rd_data_valid : read return, driven by the slave side
interface bus_if;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  logic [ADDR_W-1:0] addr;
  logic              wr;
  logic [DATA_W-1:0] wr_data;
  logic              rd;
  logic [DATA_W-1:0] rd_data;
  logic              rd_data_valid;

  modport master (
    output addr, wr, wr_data, rd,
    input  rd_data, rd_data_valid
  );

  modport slave (
    input  addr, wr, wr_data, rd,
    output rd_data, rd_data_valid
  );
endinterface

// File: rtl/bridge_dataslot_size_override.sv
// Dataslot size override bridge. Watches host reads of the dataslot table,
// learns where each configured slot id lives, and substitutes a replacement
// size_lower word on read-back. Host writes to a learned size word are flagged.
//   clk, reset            : clock, asynchronous active-high reset
//   bridge_dataslot_in    : host-facing port (slave)
//   bridge_dataslot_out   : table-RAM-facing port (master)
//   slot_id/slot_size/override_en : per-channel match id, replacement size, enable
//   slot_found/slot_base  : per-channel learned flag and entry byte address
//   size_wr_pulse         : per-channel one-cycle pulse on host size-word write
module bridge_dataslot_size_override #(
  parameter int unsigned NUM_SLOTS     = 4,
  parameter logic [31:0] TABLE_BASE    = 32'hF8002000,
  parameter int unsigned TABLE_ENTRIES = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  bus_if.slave                          bridge_dataslot_in,
  bus_if.master                         bridge_dataslot_out,
  input  logic [NUM_SLOTS-1:0][15:0]    slot_id,
  input  logic [NUM_SLOTS-1:0][31:0]    slot_size,
  input  logic [NUM_SLOTS-1:0]          override_en,
  output logic [NUM_SLOTS-1:0]          slot_found,
  output logic [NUM_SLOTS-1:0][31:0]    slot_base,
  output logic [NUM_SLOTS-1:0]          size_wr_pulse
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ID_W   = 16;
  localparam logic [ADDR_W-1:0] TABLE_END  = TABLE_BASE + ADDR_W'(8 * TABLE_ENTRIES);
  localparam logic [ADDR_W-1:0] SIZE_OFFS  = ADDR_W'(4);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t                           state_q, state_d;
  logic                             tag_load;
  logic [ADDR_W-1:0]                tag_q;
  logic                             learn_valid;
  logic                             in_table;
  logic                             is_word0;
  logic                             is_word1;
  logic [DATA_W-1:0]                rd_data_d;
  logic [DATA_W-1:0]                rd_data_q;
  logic                             rd_valid_q;
  logic [NUM_SLOTS-1:0]             found_d, found_q;
  logic [NUM_SLOTS-1:0][ADDR_W-1:0] base_d, base_q;
  logic [NUM_SLOTS-1:0]             pulse_d, pulse_q;

  // Request side passes straight through, untouched by reset.
  assign bridge_dataslot_out.addr    = bridge_dataslot_in.addr;
  assign bridge_dataslot_out.wr      = bridge_dataslot_in.wr;
  assign bridge_dataslot_out.wr_data = bridge_dataslot_in.wr_data;
  assign bridge_dataslot_out.rd      = bridge_dataslot_in.rd;

  assign bridge_dataslot_in.rd_data       = rd_data_q;
  assign bridge_dataslot_in.rd_data_valid = rd_valid_q;

  assign slot_found    = found_q;
  assign slot_base     = base_q;
  assign size_wr_pulse = pulse_q;

  // Read tracking state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Read tracking next state; a new rd always re-tags, even as data returns.
  always_comb begin
    state_d  = state_q;
    tag_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bridge_dataslot_in.rd) begin
          tag_load = 1'b1;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bridge_dataslot_in.rd) begin
          tag_load = 1'b1;
          state_d  = ST_WAIT;
        end else if (bridge_dataslot_out.rd_data_valid) begin
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Address of the outstanding read; returning data belongs to this address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_q <= '0;
    end else if (tag_load) begin
      tag_q <= bridge_dataslot_in.addr;
    end
  end

  // Only data answering a tracked read is used for learning or override.
  assign learn_valid = (state_q == ST_WAIT) && bridge_dataslot_out.rd_data_valid;
  assign in_table    = (tag_q >= TABLE_BASE) && (tag_q < TABLE_END);
  assign is_word0    = in_table && (tag_q[2:0] == 3'b000);
  assign is_word1    = in_table && (tag_q[2:0] == 3'b100);

  // Size substitution; descending scan so the lowest matching channel wins.
  always_comb begin
    rd_data_d = bridge_dataslot_out.rd_data;
    for (int k = int'(NUM_SLOTS) - 1; k >= 0; k--) begin
      if (learn_valid && is_word1 && found_q[k] && override_en[k] &&
          (tag_q == base_q[k] + SIZE_OFFS)) begin
        rd_data_d = slot_size[k];
      end
    end
  end

  // Learning (sticky found flag, last read wins for base) and write detect.
  always_comb begin
    found_d = found_q;
    base_d  = base_q;
    pulse_d = '0;
    for (int k = 0; k < int'(NUM_SLOTS); k++) begin
      if (learn_valid && is_word0 &&
          (bridge_dataslot_out.rd_data[ID_W-1:0] == slot_id[k])) begin
        found_d[k] = 1'b1;
        base_d[k]  = tag_q;
      end
      if (bridge_dataslot_in.wr && found_q[k] &&
          (bridge_dataslot_in.addr == base_q[k] + SIZE_OFFS)) begin
        pulse_d[k] = 1'b1;
      end
    end
  end

  // Upstream return stage and per-channel state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      found_q    <= '0;
      base_q     <= '0;
      pulse_q    <= '0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= bridge_dataslot_out.rd_data_valid;
      found_q    <= found_d;
      base_q     <= base_d;
      pulse_q    <= pulse_d;
    end
  end

endmodule

// File: doc/bridge_dataslot_size_override.md
BRIDGE_DATASLOT_SIZE_OVERRIDE -- requirements
Module: bridge_dataslot_size_override

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 4: number of independently overridden dataslots, range 1..16.
REQ-002 SHALL have parameter TABLE_BASE, default 32'hF8002000: byte address of dataslot table entry 0.
REQ-003 SHALL have parameter TABLE_ENTRIES, default 32: entries in table, 8 bytes each; word0 {params[31:16], slot_id[15:0]}, word1 size_lower.
REQ-004 SHALL have port clk, input, 1: single clock for all logic.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port bridge_dataslot_in, bus_if, -: upstream (host-facing) bridge port.
REQ-007 SHALL have port bridge_dataslot_out, bus_if, -: downstream (table RAM-facing) bridge port.
REQ-008 SHALL have port slot_id, input, NUM_SLOTS x 16: slot id matched per channel.
REQ-009 SHALL have port slot_size, input, NUM_SLOTS x 32: replacement size_lower per channel.
REQ-010 SHALL have port override_en, input, NUM_SLOTS: per-channel replace enable.
REQ-011 SHALL have port slot_found, output, NUM_SLOTS: channel's table entry learned.
REQ-012 SHALL have port slot_base, output, NUM_SLOTS x 32: learned entry byte address per channel.
REQ-013 SHALL have port size_wr_pulse, output, NUM_SLOTS: one-cycle pulse when host writes the channel's size word.

Function
REQ-014 SHALL pass addr, wr, wr_data, rd combinationally in->out, unmodified, zero latency.
REQ-015 SHALL return rd_data/rd_data_valid upstream through one register stage: upstream valid = downstream valid delayed exactly 1 cycle.
REQ-016 SHALL track reads with FSM IDLE/WAIT: rd in IDLE latches addr, goes WAIT; downstream rd_data_valid in WAIT returns IDLE.
REQ-017 SHALL, on rd while in WAIT (including same cycle as rd_data_valid), latch the new addr and stay/enter WAIT; the returning data is tagged with the previously latched addr.
REQ-018 SHALL treat a tagged addr as table word0 when TABLE_BASE <= addr < TABLE_BASE+8*TABLE_ENTRIES and addr[2:0]==0; word1 when addr[2:0]==3'b100.
REQ-019 SHALL, on valid word0 data whose slot_id[15:0] equals slot_id[k], set slot_found[k]=1 and slot_base[k]=tagged addr, for every matching k in the same cycle.
REQ-020 SHALL, on re-learn of an already-found channel at a different address, overwrite slot_base[k] (last read wins).
REQ-021 SHALL, on valid word1 data at slot_base[k]+4 with slot_found[k] and override_en[k], register slot_size[k] as upstream rd_data; otherwise register downstream rd_data unchanged.
REQ-022 SHALL, when several channels match the same word1, use the lowest k.
REQ-023 SHALL, on valid word0 data for a found channel k whose slot_id no longer matches, leave slot_found[k] set (learning is sticky until reset).
REQ-024 SHALL, on wr to slot_base[k]+4 with slot_found[k], assert size_wr_pulse[k] the following cycle for exactly 1 cycle, for every matching k.
REQ-025 SHALL sample slot_id, slot_size, override_en in the cycle rd_data_valid arrives; changes affect only later returns.
REQ-026 SHALL ignore rd_data_valid received in IDLE for learning/override; data still passes with 1-cycle latency.
REQ-027 SHALL compute all address arithmetic in 32 bits; entries beyond TABLE_ENTRIES never match, no wrap.

Reset
REQ-028 SHALL, on reset assertion, asynchronously clear: FSM=IDLE, slot_found=0, slot_base=0, size_wr_pulse=0, upstream rd_data_valid=0, upstream rd_data=0.
REQ-029 SHALL discard a read outstanding at reset; its late rd_data_valid after release is handled per REQ-026.
REQ-030 SHALL leave pass-through signals of REQ-014 unaffected by reset.

Verification
REQ-031 Learn/override: slot_id[1]=16'h0003, en[1]=1, size[1]=32'h1234; read F8002010 returns 32'h00000003, then read F8002014 returns 32'h0000FFFF -> slot_found[1]=1, slot_base[1]=F8002010, second upstream data 32'h1234, each valid 1 cycle after downstream.
REQ-032 Override disabled: same as REQ-031 with en[1]=0 -> upstream 32'h0000FFFF.
REQ-033 Back-to-back reads: rd F8002000 then rd F8002008 before first data returns -> data tagged F8002008 only; no learn at F8002000.
REQ-034 Write detect: after REQ-031, wr F8002014 -> size_wr_pulse[1] high exactly 1 cycle, other bits 0; wr F8002018 -> no pulse.
REQ-035 Out of range: word0 read at TABLE_BASE+8*TABLE_ENTRIES returning matching id -> no slot_found change.
REQ-036 Reset mid-read: reset asserted while WAIT, data returns after release -> no learn, upstream data passes unchanged, slot_found all 0.
